serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Serial transmitter: accepts a parallel word over a valid/ready handshake and drives it onto a single idle-high line.
- Frame order: start bit, data bits LSB first, optional even-parity bit, stop bit.
- Sits at the transmit end of the team's point-to-point serial link and feeds the matching line receiver.
- All state is held in reset-able flip-flops clocked on the rising edge of clk.

Parameters:
- DATA_W, 8: data bits per frame (>=1).
- CLK_DIV, 4: clk cycles per line bit (>=1; 1 is legal).
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_data  input  DATA_W  word to send; sampled only on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line, idle high, registered.
- busy  output  1  frame in progress (equals ~tx_ready).

Behaviour:
- Reset (async assert, any time): tx_out=1, tx_ready=1, busy=0, state=IDLE, bit and div counters=0, shift register=0. Takes effect immediately, without a clock edge. Deassertion is synchronous to clk by system design.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake: a word is accepted at the rising edge where tx_valid=1 and tx_ready=1. tx_valid while tx_ready=0 is ignored. tx_data changes during a frame have no effect.
- Acceptance edge E:
  - tx_data is loaded into the shift register.
  - Parity is latched as the XOR of all data bits.
  - tx_out<=0 (start bit); state<=START; tx_ready<=0; div counter<=0.
- Bit timing:
  - Each line bit holds for exactly CLK_DIV cycles.
  - The div counter counts 0..CLK_DIV-1. At terminal count the next bit is driven on the same edge and the counter wraps to 0.
- Transitions, taken at terminal count:
  - START->DATA: drive bit 0.
  - DATA: shift right and drive the next bit. After bit DATA_W-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: drive the parity bit, then STOP.
  - STOP: drive 1 for CLK_DIV cycles, then IDLE.
- Frame length F = (2 + DATA_W + PARITY_EN) * CLK_DIV cycles.
- tx_ready returns to 1 at edge E+F, with tx_out=1.
- The earliest next acceptance is edge E+F+1, so there is at least 1 idle-high cycle between frames. With tx_valid held high, the next start bit is driven at E+F+1.
- Parity: even, so the total count of ones across data plus parity is even.
- Counter widths:
  - Div counter: clog2(CLK_DIV) bits, minimum 1 bit.
  - Bit counter: clog2(DATA_W) bits, minimum 1 bit.
  - No counter may overflow for any legal parameter value.
- Reset mid-frame aborts the frame with no further line activity. The next handshake after reset produces a complete, normal frame.

Decomposition:
- Package serial_link_pkg:
  - State enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Constant LINE_IDLE=1'b1.
  - Function frame_cycles(DATA_W, CLK_DIV, PARITY_EN).
  - Shared with the receiver.
- Sub-module serial_bit_timer:
  - Parameter CLK_DIV; inputs clk, rst_n, clear, en; output tick.
  - tick is high on the terminal-count cycle.
  - Reused by the receiver.

Test Plan (DATA_W=8, CLK_DIV=4, PARITY_EN=1 unless stated):
- Reset: rst_n=0 with clk stopped -> tx_out=1, tx_ready=1, busy=0 immediately. Release rst_n and hold for 10 cycles -> outputs unchanged.
- Send 0xA5 at edge E:
  - tx_out over 4-cycle bits is 0 | 1,0,1,0,0,1,0,1 | 0 (parity) | 1.
  - tx_ready=0 for 44 cycles and returns to 1 at E+44.
- Back-to-back with tx_valid held: send 0x01 then 0xFF.
  - Second start bit begins at E+45.
  - 0x01 frame has parity bit 1; 0xFF frame has parity bit 0.
- Accept 0x3C, then drive tx_data=0xC3 with tx_valid=1 during the frame:
  - Line still carries 0x3C bits (0,0,1,1,1,1,0,0).
  - 0xC3 is accepted only at E+45.
- Assert rst_n=0 mid-DATA (bit 3):
  - tx_out=1 and tx_ready=1 without a clock edge.
  - After release, sending 0x5A yields a complete, correct 44-cycle frame.
- PARITY_EN=0, CLK_DIV=1: send 0x3C -> line 0,0,0,1,1,1,1,0,0,1 over 10 cycles; tx_ready high at E+10.

Source files
------------

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared types, constants and helpers for the serial link
// Contents: tx_state_t frame FSM states, LINE_IDLE line level, frame_cycles() frame length.
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Clock cycles occupied by one complete frame on the line.
    function automatic int frame_cycles(input int data_w, input int clk_div, input int parity_en);
        return (2 + data_w + parity_en) * clk_div;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - divider that marks the last clk cycle of each line bit
// Ports: clk, rst_n (async, active-low), clear (restart count at 0),
//        en (count while high), tick (high on terminal-count cycle).
module serial_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = en && (cnt_q == DIV_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            // Wrap at terminal count so the counter never exceeds CLK_DIV-1.
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-in serial transmitter: start, data LSB first, even parity, stop
// Ports: clk, rst_n (async, active-low), tx_data/tx_valid/tx_ready word handshake,
//        tx_out registered idle-high line, busy (frame in progress, ~tx_ready).
module serial_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    tx_state_t         state_q,   state_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              parity_q,  parity_d;
    logic              tx_out_q,  tx_out_d;
    logic              ready_q,   ready_d;

    logic accept;
    logic tick;

    assign accept   = tx_valid && ready_q;
    assign tx_ready = ready_q;
    assign busy     = ~ready_q;
    assign tx_out   = tx_out_q;

    // Timer is restarted on acceptance and idles at zero between frames.
    serial_bit_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(accept),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_out_d  = tx_out_q;
        ready_d   = ready_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d  = tx_data;
                    parity_d = ^tx_data;
                    tx_out_d = 1'b0;
                    state_d  = START;
                    ready_d  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    // Drive bit 0 and pre-shift so shreg[0] always holds the next bit.
                    tx_out_d  = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            tx_out_d = parity_q;
                            state_d  = PARITY;
                        end else begin
                            tx_out_d = LINE_IDLE;
                            state_d  = STOP;
                        end
                    end else begin
                        tx_out_d  = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_out_d = LINE_IDLE;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = LINE_IDLE;
                ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_out_q  <= LINE_IDLE;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_out_q  <= tx_out_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed, table-driven bench for serial_tx
module tb_serial_tx;
    import serial_link_pkg::*;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;
    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       tx_out2;
    logic       busy2;

    int n_checks = 0;
    int n_fail   = 0;

    serial_tx #(.DATA_W(8), .CLK_DIV(4), .PARITY_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy)
    );

    serial_tx #(.DATA_W(8), .CLK_DIV(1), .PARITY_EN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx_out(tx_out2), .busy(busy2)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Frame encoding: {stop, parity, data[7:0], start}; bit i is the i-th line bit.
    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (tx_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wait_ready_timeout", 32'(tx_ready), 32'd1);
    endtask

    // Called #1 after acceptance edge E; ends on the negedge following E+44.
    task automatic check_frame(input logic [10:0] exp, input string name);
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            chk({name, "_line"}, 32'(tx_out), 32'(exp[c/4]));
            chk({name, "_busy"}, 32'({tx_ready, busy}), 32'b01);
        end
        @(negedge clk);
        chk({name, "_ready_end"}, 32'({tx_ready, busy, tx_out}), 32'b101);
    endtask

    task automatic accept_word(input logic [7:0] d);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [9:0] exp2;
        clk_en    = 1'b0;
        rst_n     = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data2  = 8'h00;
        tx_valid2 = 1'b0;

        vecs[0] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}};
        vecs[1] = '{8'h00, {1'b1, 1'b0, 8'h00, 1'b0}};
        vecs[2] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}};
        vecs[3] = '{8'h7F, {1'b1, 1'b1, 8'h7F, 1'b0}};
        vecs[4] = '{8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}};

        chk("frame_cycles", 32'(frame_cycles(8, 4, 1)), 32'd44);

        // Reset with clock stopped takes effect immediately.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({tx_out, tx_ready, busy}), 32'b110);
        chk("rst_async2", 32'({tx_out2, tx_ready2, busy2}), 32'b110);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_hold", 32'({tx_out, tx_ready, busy}), 32'b110);
        end

        // Table of isolated frames.
        foreach (vecs[i]) begin
            accept_word(vecs[i].data);
            check_frame(vecs[i].frame, $sformatf("vec%0d", i));
        end

        // Back-to-back with tx_valid held: 0x01 (parity 1) then 0xFF (parity 0).
        wait_ready();
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'hFF;
        check_frame({1'b1, 1'b1, 8'h01, 1'b0}, "b2b_01");
        @(posedge clk);
        #1;
        chk("b2b_accept_e45", 32'({tx_ready, tx_out}), 32'b00);
        tx_valid = 1'b0;
        check_frame({1'b1, 1'b0, 8'hFF, 1'b0}, "b2b_ff");

        // Data changes during a frame are ignored; pending word waits for E+45.
        wait_ready();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'hC3;
        check_frame({1'b1, 1'b0, 8'h3C, 1'b0}, "hold_3c");
        @(posedge clk);
        #1;
        chk("hold_accept_e45", 32'({tx_ready, tx_out}), 32'b00);
        tx_valid = 1'b0;
        check_frame({1'b1, 1'b0, 8'hC3, 1'b0}, "hold_c3");

        // Reset in the middle of data bit 3 (line bit 4, cycles 16..19).
        accept_word(8'hFF);
        repeat (18) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst", 32'({tx_out, tx_ready, busy}), 32'b110);
        repeat (3) @(negedge clk);
        chk("mid_rst_held", 32'({tx_out, tx_ready, busy}), 32'b110);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'({tx_out, tx_ready, busy}), 32'b110);
        accept_word(8'h5A);
        check_frame({1'b1, 1'b0, 8'h5A, 1'b0}, "post_rst_5a");

        // CLK_DIV=1, no parity: 0x3C -> 0,0,0,1,1,1,1,0,0,1.
        exp2 = 10'b1_0011_1100_0;
        @(negedge clk);
        chk("d2_ready", 32'(tx_ready2), 32'd1);
        tx_data2  = 8'h3C;
        tx_valid2 = 1'b1;
        @(posedge clk);
        #1;
        tx_valid2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("d2_line", 32'(tx_out2), 32'(exp2[c]));
            chk("d2_busy", 32'(tx_ready2), 32'd0);
        end
        @(negedge clk);
        chk("d2_ready_e10", 32'({tx_ready2, busy2, tx_out2}), 32'b101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
